// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider control stage
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } div_state_e;

    // Most negative two's-complement value for a given width; callers truncate to their width.
    function automatic logic [127:0] div_min(input int width);
        return 128'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional two's-complement negation (magnitude in, sign-corrected out)
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] result_o
);

    assign result_o = negate_i ? ('0 - value_i) : value_i;

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - handshake, sign handling and settle timing around an external combinational divider
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH         = DIV_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_by_zero,
    output logic             out_overflow,
    output logic [WIDTH-1:0] dv_dividend_o,
    output logic [WIDTH-1:0] dv_divisor_o,
    input  logic [WIDTH-1:0] dv_quotient_i,
    input  logic [WIDTH-1:0] dv_remainder_i
);

    localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(div_min(WIDTH));

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;
    logic             overflow_q;
    logic [WIDTH-1:0] dv_dividend_q;
    logic [WIDTH-1:0] dv_divisor_q;

    logic [WIDTH-1:0] mag_dividend_d;
    logic [WIDTH-1:0] mag_divisor_d;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;
    logic             accept;

    assign accept = in_valid && in_ready_q;

    div_sign_fix #(.WIDTH(WIDTH)) u_mag_dividend (
        .value_i  (in_dividend),
        .negate_i (in_signed & in_dividend[WIDTH-1]),
        .result_o (mag_dividend_d)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_mag_divisor (
        .value_i  (in_divisor),
        .negate_i (in_signed & in_divisor[WIDTH-1]),
        .result_o (mag_divisor_d)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quotient (
        .value_i  (dv_quotient_i),
        .negate_i (neg_quo_q),
        .result_o (quotient_d)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_remainder (
        .value_i  (dv_remainder_i),
        .negate_i (neg_rem_q),
        .result_o (remainder_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            dv_dividend_q <= '0;
            dv_divisor_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dv_dividend_q <= mag_dividend_d;
                        dv_divisor_q  <= mag_divisor_d;
                        neg_quo_q     <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
                        neg_rem_q     <= in_signed & in_dividend[WIDTH-1];
                        in_ready_q    <= 1'b0;
                        // Bypass cases never touch the divider; their result is known at accept.
                        if (in_divisor == '0) begin
                            quotient_q    <= '1;
                            remainder_q   <= in_dividend;
                            div_by_zero_q <= 1'b1;
                            overflow_q    <= 1'b0;
                            out_valid_q   <= 1'b1;
                            state_q       <= ST_DONE;
                        end else if (in_signed && in_dividend == MIN_VAL && in_divisor == '1) begin
                            quotient_q    <= MIN_VAL;
                            remainder_q   <= '0;
                            div_by_zero_q <= 1'b0;
                            overflow_q    <= 1'b1;
                            out_valid_q   <= 1'b1;
                            state_q       <= ST_DONE;
                        end else begin
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        quotient_q    <= quotient_d;
                        remainder_q   <= remainder_d;
                        div_by_zero_q <= 1'b0;
                        overflow_q    <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_quotient    = quotient_q;
    assign out_remainder   = remainder_q;
    assign out_div_by_zero = div_by_zero_q;
    assign out_overflow    = overflow_q;
    assign dv_dividend_o   = dv_dividend_q;
    assign dv_divisor_o    = dv_divisor_q;

endmodule
